mc_sequencer: RTL and testbench
===============================

MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 1, meaning cycles the memory address is held before read data is valid (legal 1..4).
REQ-002 SHALL have port Clk  in  1  meaning system clock, all state changes on rising edge.
REQ-003 SHALL have port Reset  in  1  meaning asynchronous active-high reset.
REQ-004 SHALL have port Op  in  6  meaning IR opcode field [31:26].
REQ-005 SHALL have port Zero  in  1  meaning ALU zero flag.
REQ-006 SHALL have port PCLoad  out  1  meaning PC register load enable (branch condition already folded in).
REQ-007 SHALL have port IorD  out  1  meaning memory address select, 0=PC, 1=ALUOut.
REQ-008 SHALL have port MemWrite  out  1  meaning memory write strobe.
REQ-009 SHALL have port MemtoReg  out  1  meaning register-file write data select, 0=ALUOut, 1=MDR.
REQ-010 SHALL have port IRWrite  out  1  meaning instruction register load.
REQ-011 SHALL have port MDRWrite  out  1  meaning memory data register load.
REQ-012 SHALL have port AWrite  out  1  meaning A register load.
REQ-013 SHALL have port BWrite  out  1  meaning B register load.
REQ-014 SHALL have port ALUOutWrite  out  1  meaning ALUOut register load.
REQ-015 SHALL have port PCSource  out  2  meaning PC input select, 00=ALU result, 01=ALUOut, 10=jump address.
REQ-016 SHALL have port ALUOp  out  3  meaning ALU control request, 000=add, 001=sub, 010=decode funct.
REQ-017 SHALL have port ALUSrcA  out  1  meaning ALU A select, 0=PC, 1=A.
REQ-018 SHALL have port ALUSrcB  out  2  meaning ALU B select, 00=B, 01=const 4, 10=sign-ext, 11=sign-ext<<2.
REQ-019 SHALL have port RegWrite  out  1  meaning register-file write enable.
REQ-020 SHALL have port RegDst  out  1  meaning write register select, 0=rt, 1=rd.
REQ-021 SHALL have port Halted  out  1  meaning sticky illegal-opcode indication.
REQ-022 SHALL have port State  out  4  meaning current state encoding (debug/verification).

Function
REQ-023 SHALL be a Moore FSM; all outputs decode from state only, except PCLoad in BRANCH, which SHALL equal Zero.
REQ-024 SHALL encode states RST=0, FETCH=1, FETCH_WAIT=2, DECODE=3, MEM_ADDR=4, MEM_READ=5, MEM_WAIT=6, MEM_WB=7, MEM_WRITE=8, R_EXEC=9, R_WB=10, BRANCH=11, JUMP=12, ADDI_EXEC=13, ADDI_WB=14, HALT=15.
REQ-025 SHALL drive every output not listed for a state to 0.
REQ-026 SHALL transition RST->FETCH unconditionally.
REQ-027 SHALL hold FETCH and MEM_READ for exactly READ_LATENCY cycles each via an internal down-counter reloaded on entry, with IorD=0 in FETCH and IorD=1 in MEM_READ.
REQ-028 SHALL assert in FETCH_WAIT: IRWrite, PCLoad, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00; next state DECODE.
REQ-029 SHALL assert in DECODE: AWrite, BWrite, ALUOutWrite, ALUSrcA=0, ALUSrcB=11, ALUOp=000; sample Op and dispatch 100011/101011->MEM_ADDR, 000000->R_EXEC, 000100->BRANCH, 000010->JUMP, 001000->ADDI_EXEC, any other value->HALT.
REQ-030 SHALL assert in MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000, ALUOutWrite; next state MEM_READ for 100011, MEM_WRITE for 101011 (Op held stable by IR).
REQ-031 SHALL assert IorD=1 and MDRWrite in MEM_WAIT (next MEM_WB), and RegWrite, MemtoReg=1, RegDst=0 in MEM_WB (next FETCH).
REQ-032 SHALL assert IorD=1 and MemWrite for exactly one cycle in MEM_WRITE; next state FETCH.
REQ-033 SHALL assert in R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010, ALUOutWrite (next R_WB); in R_WB: RegWrite, RegDst=1, MemtoReg=0 (next FETCH).
REQ-034 SHALL assert in BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01, PCLoad=Zero; next state FETCH.
REQ-035 SHALL assert in JUMP: PCSource=10, PCLoad; next state FETCH.
REQ-036 SHALL assert in ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=000, ALUOutWrite (next ADDI_WB); in ADDI_WB: RegWrite, RegDst=0, MemtoReg=0 (next FETCH).
REQ-037 SHALL remain in HALT with Halted=1 and all enables 0 until Reset.
REQ-038 SHALL give fetch-to-fetch latencies, with L=READ_LATENCY: R-type/sw/addi L+4, beq/j L+3, lw 2L+5 cycles.

Reset
REQ-039 SHALL on Reset=1 force State=RST, counter=0, and all outputs (including Halted) to 0 asynchronously, from any state.
REQ-040 SHALL on Reset deassertion spend one cycle in RST, then enter FETCH.

Verification
REQ-041 Reset asserted while State=8 -> MemWrite=0 and State=0 before next edge; after release State sequence 0,1.
REQ-042 Op=000000, L=1 -> State 1,2,3,9,10,1; RegWrite=1 with RegDst=1 only in state 10; IRWrite high exactly one cycle.
REQ-043 Op=100011, READ_LATENCY=3 -> FETCH and MEM_READ each 3 cycles; MDRWrite one cycle in state 6; fetch-to-fetch 11 cycles.
REQ-044 Op=000100 with Zero=1 then Zero=0 -> PCLoad=1 then 0 in state 11; PCSource=01, ALUOp=001 both times.
REQ-045 Op=111111 -> DECODE->HALT; Halted=1, all enables 0 for 100 cycles; Reset clears Halted to 0.
REQ-046 Op=000010, L=1 -> State 1,2,3,12,1; PCSource=10 and PCLoad=1 in state 12.

Source files
------------

// File: rtl/mc_sequencer.sv
// Multi-cycle CPU control sequencer: Moore FSM that steps fetch/decode/execute
// and drives datapath enables and mux selects from the current state.
module mc_sequencer #(
  parameter int READ_LATENCY = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  output logic       PCLoad,
  output logic       IorD,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       AWrite,
  output logic       BWrite,
  output logic       ALUOutWrite,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       Halted,
  output logic [3:0] State
);

  localparam logic [3:0] S_RST        = 4'd0;
  localparam logic [3:0] S_FETCH      = 4'd1;
  localparam logic [3:0] S_FETCH_WAIT = 4'd2;
  localparam logic [3:0] S_DECODE     = 4'd3;
  localparam logic [3:0] S_MEM_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM_READ   = 4'd5;
  localparam logic [3:0] S_MEM_WAIT   = 4'd6;
  localparam logic [3:0] S_MEM_WB     = 4'd7;
  localparam logic [3:0] S_MEM_WRITE  = 4'd8;
  localparam logic [3:0] S_R_EXEC     = 4'd9;
  localparam logic [3:0] S_R_WB       = 4'd10;
  localparam logic [3:0] S_BRANCH     = 4'd11;
  localparam logic [3:0] S_JUMP       = 4'd12;
  localparam logic [3:0] S_ADDI_EXEC  = 4'd13;
  localparam logic [3:0] S_ADDI_WB    = 4'd14;
  localparam logic [3:0] S_HALT       = 4'd15;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // Counter holds remaining wait cycles minus one, so 0 means "leave next edge".
  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  logic [3:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RST:        state_d = S_FETCH;
      S_FETCH:      if (cnt_q == 2'd0) state_d = S_FETCH_WAIT;
                    else cnt_d = cnt_q - 2'd1;
      S_FETCH_WAIT: state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEM_ADDR:   state_d = (Op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:   if (cnt_q == 2'd0) state_d = S_MEM_WAIT;
                    else cnt_d = cnt_q - 2'd1;
      S_MEM_WAIT:   state_d = S_MEM_WB;
      S_R_EXEC:     state_d = S_R_WB;
      S_ADDI_EXEC:  state_d = S_ADDI_WB;
      S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB:
                    state_d = S_FETCH;
      default:      state_d = S_HALT;
    endcase
    // Any entry into a memory-wait state reloads the latency counter.
    if ((state_d == S_FETCH || state_d == S_MEM_READ) && state_d != state_q)
      cnt_d = CNT_INIT;
  end

  always_comb begin
    PCLoad      = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    MDRWrite    = 1'b0;
    AWrite      = 1'b0;
    BWrite      = 1'b0;
    ALUOutWrite = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 3'b000;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    Halted      = 1'b0;
    case (state_q)
      S_FETCH_WAIT: begin IRWrite = 1'b1; PCLoad = 1'b1; ALUSrcB = 2'b01; end
      S_DECODE: begin
        AWrite = 1'b1; BWrite = 1'b1; ALUOutWrite = 1'b1; ALUSrcB = 2'b11;
      end
      S_MEM_ADDR:   begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUOutWrite = 1'b1; end
      S_MEM_READ:   IorD = 1'b1;
      S_MEM_WAIT:   begin IorD = 1'b1; MDRWrite = 1'b1; end
      S_MEM_WB:     begin RegWrite = 1'b1; MemtoReg = 1'b1; end
      S_MEM_WRITE:  begin IorD = 1'b1; MemWrite = 1'b1; end
      S_R_EXEC:     begin ALUSrcA = 1'b1; ALUOp = 3'b010; ALUOutWrite = 1'b1; end
      S_R_WB:       begin RegWrite = 1'b1; RegDst = 1'b1; end
      S_BRANCH: begin
        ALUSrcA = 1'b1; ALUOp = 3'b001; PCSource = 2'b01; PCLoad = Zero;
      end
      S_JUMP:       begin PCSource = 2'b10; PCLoad = 1'b1; end
      S_ADDI_EXEC:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUOutWrite = 1'b1; end
      S_ADDI_WB:    RegWrite = 1'b1;
      S_HALT:       Halted = 1'b1;
      default: ;
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench: stimulus queues per-cycle expected output vectors,
// a negedge monitor pops and compares them against two latency variants.
module tb_mc_sequencer;

  typedef struct packed {
    logic [3:0] st;
    logic pcl, iord, mw, m2r, irw, mdrw, aw, bw, aow;
    logic [1:0] pcs;
    logic [2:0] aop;
    logic asa;
    logic [1:0] asb;
    logic rw, rd, hlt;
  } ovec_t;

  logic Clk = 1'b0, Reset = 1'b1, Zero = 1'b0;
  logic [5:0] Op = 6'd0;

  logic PCLoad1, IorD1, MemWrite1, MemtoReg1, IRWrite1, MDRWrite1, AWrite1, BWrite1;
  logic ALUOutWrite1, ALUSrcA1, RegWrite1, RegDst1, Halted1;
  logic [1:0] PCSource1, ALUSrcB1;
  logic [2:0] ALUOp1;
  logic [3:0] State1;
  logic PCLoad3, IorD3, MemWrite3, MemtoReg3, IRWrite3, MDRWrite3, AWrite3, BWrite3;
  logic ALUOutWrite3, ALUSrcA3, RegWrite3, RegDst3, Halted3;
  logic [1:0] PCSource3, ALUSrcB3;
  logic [2:0] ALUOp3;
  logic [3:0] State3;

  ovec_t o1, o3;
  assign o1 = {State1, PCLoad1, IorD1, MemWrite1, MemtoReg1, IRWrite1, MDRWrite1, AWrite1,
               BWrite1, ALUOutWrite1, PCSource1, ALUOp1, ALUSrcA1, ALUSrcB1, RegWrite1,
               RegDst1, Halted1};
  assign o3 = {State3, PCLoad3, IorD3, MemWrite3, MemtoReg3, IRWrite3, MDRWrite3, AWrite3,
               BWrite3, ALUOutWrite3, PCSource3, ALUOp3, ALUSrcA3, ALUSrcB3, RegWrite3,
               RegDst3, Halted3};

  mc_sequencer #(.READ_LATENCY(1)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Zero(Zero), .PCLoad(PCLoad1), .IorD(IorD1),
    .MemWrite(MemWrite1), .MemtoReg(MemtoReg1), .IRWrite(IRWrite1), .MDRWrite(MDRWrite1),
    .AWrite(AWrite1), .BWrite(BWrite1), .ALUOutWrite(ALUOutWrite1), .PCSource(PCSource1),
    .ALUOp(ALUOp1), .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1), .RegWrite(RegWrite1),
    .RegDst(RegDst1), .Halted(Halted1), .State(State1));

  mc_sequencer #(.READ_LATENCY(3)) u_dut3 (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Zero(Zero), .PCLoad(PCLoad3), .IorD(IorD3),
    .MemWrite(MemWrite3), .MemtoReg(MemtoReg3), .IRWrite(IRWrite3), .MDRWrite(MDRWrite3),
    .AWrite(AWrite3), .BWrite(BWrite3), .ALUOutWrite(ALUOutWrite3), .PCSource(PCSource3),
    .ALUOp(ALUOp3), .ALUSrcA(ALUSrcA3), .ALUSrcB(ALUSrcB3), .RegWrite(RegWrite3),
    .RegDst(RegDst3), .Halted(Halted3), .State(State3));

  always #5 Clk = ~Clk;

  int total = 0, bad = 0;
  ovec_t q1[$], q3[$];

  // Hand-written per-state output table.
  function automatic ovec_t model(logic [3:0] s, logic z);
    ovec_t v = '0;
    v.st = s;
    case (s)
      4'd2:  begin v.irw = 1; v.pcl = 1; v.asb = 2'b01; end
      4'd3:  begin v.aw = 1; v.bw = 1; v.aow = 1; v.asb = 2'b11; end
      4'd4:  begin v.asa = 1; v.asb = 2'b10; v.aow = 1; end
      4'd5:  v.iord = 1;
      4'd6:  begin v.iord = 1; v.mdrw = 1; end
      4'd7:  begin v.rw = 1; v.m2r = 1; end
      4'd8:  begin v.iord = 1; v.mw = 1; end
      4'd9:  begin v.asa = 1; v.aop = 3'b010; v.aow = 1; end
      4'd10: begin v.rw = 1; v.rd = 1; end
      4'd11: begin v.asa = 1; v.aop = 3'b001; v.pcs = 2'b01; v.pcl = z; end
      4'd12: begin v.pcs = 2'b10; v.pcl = 1; end
      4'd13: begin v.asa = 1; v.asb = 2'b10; v.aow = 1; end
      4'd14: v.rw = 1;
      4'd15: v.hlt = 1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input ovec_t a, input ovec_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s exp_state=%0d got=%h want=%h", nm, e.st, a, e);
    end
  endtask

  always @(negedge Clk) begin : mon
    ovec_t e;
    if (q1.size() != 0) begin e = q1.pop_front(); chk("dut_L1", o1, e); end
    if (q3.size() != 0) begin e = q3.pop_front(); chk("dut_L3", o3, e); end
  end

  task automatic push(input bit d3, input logic [3:0] s);
    if (d3) q3.push_back(model(s, Zero));
    else    q1.push_back(model(s, Zero));
  endtask

  // Push n states, written left-to-right as hex nibbles in v.
  task automatic seq(input bit d3, input int n, input logic [63:0] v);
    for (int i = n - 1; i >= 0; i--) push(d3, v[4*i +: 4]);
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q3.size() != 0) && n < 400) begin
      @(negedge Clk); #1; n++;
    end
    if (q1.size() != 0 || q3.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout left1=%0d left3=%0d want=0", q1.size(), q3.size());
      q1.delete(); q3.delete();
    end
  endtask

  // Reset held one cycle (checked), released just after an edge: one RST cycle.
  task automatic start(input bit d3);
    Reset = 1'b1;
    @(posedge Clk); #1; push(d3, 4'd0);
    @(posedge Clk); #1; Reset = 1'b0; push(d3, 4'd0);
  endtask

  initial begin
    // R-type, L=1: L+4 cycles fetch-to-fetch
    Op = 6'b000000; start(0); seq(0, 6, 64'h1239A1); drain();
    // R-type, L=3
    start(1); seq(1, 8, 64'h111239A1); drain();
    // lw, L=3: 2L+5 = 11
    Op = 6'b100011; start(1); seq(1, 12, 64'h111234555671); drain();
    // lw, L=1
    start(0); seq(0, 8, 64'h12345671); drain();
    // beq taken then not taken
    Op = 6'b000100; Zero = 1'b1; start(0); seq(0, 5, 64'h123B1); drain();
    Zero = 1'b0; start(0); seq(0, 5, 64'h123B1); drain();
    // jump
    Op = 6'b000010; start(0); seq(0, 5, 64'h123C1); drain();
    // addi
    Op = 6'b001000; start(0); seq(0, 6, 64'h123DE1); drain();
    // sw full path
    Op = 6'b101011; start(0); seq(0, 6, 64'h123481); drain();
    // sw with reset landing in MEM_WRITE
    start(0); seq(0, 4, 64'h1234); drain();
    @(posedge Clk); #1;
    chk("in_memwrite", o1, model(4'd8, Zero));
    Reset = 1'b1; #1;
    chk("rst_async_memwrite", o1, model(4'd0, Zero));
    @(posedge Clk); #1; Reset = 1'b0;
    push(0, 4'd0); seq(0, 1, 64'h1); drain();
    // illegal opcode: sticky HALT, then reset clears it
    Op = 6'b111111; start(0); seq(0, 4, 64'h123F);
    for (int i = 0; i < 100; i++) push(0, 4'd15);
    drain();
    Reset = 1'b1; #1;
    chk("halt_cleared", o1, model(4'd0, Zero));
    @(posedge Clk); #1; Reset = 1'b0;
    push(0, 4'd0); seq(0, 2, 64'h12); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
